// File: rtl/ram_sdp_pkg.sv
// Shared types and elaboration helpers for the single-clock simple-dual-port RAM
// with a hardware clear sequencer.
package ram_sdp_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    function automatic int nbytes(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

    function automatic bit latency_ok(input int read_latency);
        return (read_latency == 1) || (read_latency == 2);
    endfunction

    function automatic bit width_ok(input int data_width, input int byte_width);
        return (byte_width > 0) && ((data_width % byte_width) == 0);
    endfunction

endpackage

// File: rtl/ram_sdp_core.sv
// Bare storage array: per-lane write enables and one registered read port.
// The array itself is never reset; only the read register is.
module ram_sdp_core
    import ram_sdp_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]    wr_en,
    input  logic [ADDR_WIDTH-1:0]               wr_addr,
    input  logic [DATA_WIDTH-1:0]               wr_data,
    input  logic                                rd_en,
    input  logic [ADDR_WIDTH-1:0]               rd_addr,
    output logic [DATA_WIDTH-1:0]               rd_data
);

    localparam int NBYTES = nbytes(DATA_WIDTH, BYTE_WIDTH);
    localparam int DEPTH  = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NBYTES; i++) begin
            if (wr_en[i]) begin
                mem[wr_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Nonblocking write above means a same-edge read sees the old word.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ram_sdp_clear.sv
// Simple-dual-port RAM top: clear sequencer, write-port mux, collision bypass
// and the optional second read stage with its valid strobe.
module ram_sdp_clear
    import ram_sdp_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 16,
    parameter int                    ADDR_WIDTH   = 8,
    parameter int                    BYTE_WIDTH   = 8,
    parameter int                    READ_LATENCY = 1,
    parameter int                    WRITE_FIRST  = 0,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE  = '0
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [DATA_WIDTH-1:0]               data,
    input  logic [ADDR_WIDTH-1:0]               write_addr,
    input  logic                                we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]    be,
    input  logic [ADDR_WIDTH-1:0]               read_addr,
    input  logic                                re,
    input  logic                                clear_req,
    output logic                                busy,
    output logic [DATA_WIDTH-1:0]               q,
    output logic                                q_valid
);

    localparam int                    NBYTES    = nbytes(DATA_WIDTH, BYTE_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    if (!latency_ok(READ_LATENCY)) begin : g_bad_latency
        $error("ram_sdp_clear: READ_LATENCY must be 1 or 2");
    end
    if (!width_ok(DATA_WIDTH, BYTE_WIDTH)) begin : g_bad_width
        $error("ram_sdp_clear: DATA_WIDTH must be a multiple of BYTE_WIDTH");
    end

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [NBYTES-1:0]     wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_accept;
    logic [NBYTES-1:0]     byp_lanes_q, byp_lanes_d;
    logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;
    logic                  valid1_q, valid1_d;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] lane_mask;
    logic [DATA_WIDTH-1:0] q1;

    // Clear owns the write port; a clear request swallows same-cycle user access.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_en     = '0;
        wr_addr   = write_addr;
        wr_data   = data;
        rd_accept = 1'b0;
        case (state_q)
            CLEAR: begin
                wr_en   = '1;
                wr_addr = cnt_q;
                wr_data = CLEAR_VALUE;
                cnt_d   = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end else begin
                    if (we) begin
                        wr_en = be;
                    end
                    rd_accept = re;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // Remember which lanes a colliding write replaced so the read result can be patched.
    always_comb begin
        byp_lanes_d = byp_lanes_q;
        byp_data_d  = byp_data_q;
        valid1_d    = rd_accept;
        if (rd_accept) begin
            byp_data_d  = data;
            byp_lanes_d = ((WRITE_FIRST != 0) && (write_addr == read_addr)) ? wr_en : '0;
        end
    end

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < NBYTES; i++) begin
            lane_mask[i*BYTE_WIDTH +: BYTE_WIDTH] = {BYTE_WIDTH{byp_lanes_q[i]}};
        end
        q1 = (rd_data & ~lane_mask) | (byp_data_q & lane_mask);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= CLEAR;
            cnt_q       <= '0;
            byp_lanes_q <= '0;
            byp_data_q  <= '0;
            valid1_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            byp_lanes_q <= byp_lanes_d;
            byp_data_q  <= byp_data_d;
            valid1_q    <= valid1_d;
        end
    end

    ram_sdp_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BYTE_WIDTH (BYTE_WIDTH)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_accept),
        .rd_addr (read_addr),
        .rd_data (rd_data)
    );

    if (READ_LATENCY == 2) begin : g_lat2
        logic [DATA_WIDTH-1:0] q2_q, q2_d;
        logic                  valid2_q, valid2_d;

        always_comb begin
            q2_d     = valid1_q ? q1 : q2_q;
            valid2_d = valid1_q;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                q2_q     <= '0;
                valid2_q <= 1'b0;
            end else begin
                q2_q     <= q2_d;
                valid2_q <= valid2_d;
            end
        end

        assign q       = q2_q;
        assign q_valid = valid2_q;
    end else begin : g_lat1
        assign q       = q1;
        assign q_valid = valid1_q;
    end

    assign busy = (state_q == CLEAR);

endmodule

// File: tb/tb_ram_sdp_clear.sv
// Scoreboard bench: one DUT at latency 1 / read-first, one at latency 2 / write-first,
// both driven by the same stimulus and checked against a behavioural memory model.
module tb_ram_sdp_clear;

    logic        clk;
    logic        rst;
    logic [15:0] data;
    logic [3:0]  write_addr;
    logic        we;
    logic [1:0]  be;
    logic [3:0]  read_addr;
    logic        re;
    logic        clear_req;

    logic        busy_a, q_valid_a;
    logic [15:0] q_a;
    logic        busy_b, q_valid_b;
    logic [15:0] q_b;

    typedef struct {
        logic [15:0] val;
        int          due;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    logic [15:0] m_mem [16];
    logic        m_busy;
    int          m_cnt;
    int          cyc;
    int          checks;
    int          failures;

    ram_sdp_clear #(
        .DATA_WIDTH   (16),
        .ADDR_WIDTH   (4),
        .BYTE_WIDTH   (8),
        .READ_LATENCY (1),
        .WRITE_FIRST  (0),
        .CLEAR_VALUE  (16'hA5A5)
    ) dut_a (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .write_addr (write_addr),
        .we         (we),
        .be         (be),
        .read_addr  (read_addr),
        .re         (re),
        .clear_req  (clear_req),
        .busy       (busy_a),
        .q          (q_a),
        .q_valid    (q_valid_a)
    );

    ram_sdp_clear #(
        .DATA_WIDTH   (16),
        .ADDR_WIDTH   (4),
        .BYTE_WIDTH   (8),
        .READ_LATENCY (2),
        .WRITE_FIRST  (1),
        .CLEAR_VALUE  (16'hA5A5)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .write_addr (write_addr),
        .we         (we),
        .be         (be),
        .read_addr  (read_addr),
        .re         (re),
        .clear_req  (clear_req),
        .busy       (busy_b),
        .q          (q_b),
        .q_valid    (q_valid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] mergeWord(input logic [15:0] oldw, input logic [15:0] neww,
                                              input logic [1:0] lanes);
        logic [15:0] r;
        r = oldw;
        if (lanes[0]) r[7:0]  = neww[7:0];
        if (lanes[1]) r[15:8] = neww[15:8];
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic checkCycle();
        exp_t e;
        logic exp_va, exp_vb;
        checkOutput("busy_a", 32'(busy_a), 32'(m_busy));
        checkOutput("busy_b", 32'(busy_b), 32'(m_busy));
        exp_va = (qa.size() > 0) && (qa[0].due == cyc);
        exp_vb = (qb.size() > 0) && (qb[0].due == cyc);
        checkOutput("q_valid_a", 32'(q_valid_a), 32'(exp_va));
        checkOutput("q_valid_b", 32'(q_valid_b), 32'(exp_vb));
        if (exp_va) begin
            e = qa.pop_front();
            checkOutput("q_a", 32'(q_a), 32'(e.val));
        end
        if (exp_vb) begin
            e = qb.pop_front();
            checkOutput("q_b", 32'(q_b), 32'(e.val));
        end
    endtask

    task automatic applyStimulus(input logic i_we, input logic [3:0] i_wa, input logic [15:0] i_d,
                                 input logic [1:0] i_be, input logic i_re, input logic [3:0] i_ra,
                                 input logic i_clr);
        logic [15:0] oldw, wfw;
        exp_t        e;
        we         = i_we;
        write_addr = i_wa;
        data       = i_d;
        be         = i_be;
        re         = i_re;
        read_addr  = i_ra;
        clear_req  = i_clr;
        if (!m_busy && i_re && !i_clr) begin
            oldw  = m_mem[i_ra];
            wfw   = (i_we && (i_wa == i_ra)) ? mergeWord(oldw, i_d, i_be) : oldw;
            e.val = oldw; e.due = cyc + 1; qa.push_back(e);
            e.val = wfw;  e.due = cyc + 2; qb.push_back(e);
        end
        if (m_busy) begin
            m_mem[m_cnt] = 16'hA5A5;
            if (m_cnt == 15) m_busy = 1'b0;
            m_cnt = (m_cnt + 1) % 16;
        end else if (i_clr) begin
            m_busy = 1'b1;
            m_cnt  = 0;
        end else if (i_we) begin
            m_mem[i_wa] = mergeWord(m_mem[i_wa], i_d, i_be);
        end
        @(posedge clk);
        cyc++;
        #1;
        checkCycle();
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic readAddr(input logic [3:0] a);
        applyStimulus(1'b0, 4'd0, 16'h0000, 2'b00, 1'b1, a, 1'b0);
    endtask

    task automatic writeAddr(input logic [3:0] a, input logic [15:0] d, input logic [1:0] lanes);
        applyStimulus(1'b1, a, d, lanes, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_q_a"}, 32'(q_a), 32'd0);
        checkOutput({tag, "_q_b"}, 32'(q_b), 32'd0);
        checkOutput({tag, "_valid_a"}, 32'(q_valid_a), 32'd0);
        checkOutput({tag, "_valid_b"}, 32'(q_valid_b), 32'd0);
        checkOutput({tag, "_busy_a"}, 32'(busy_a), 32'd1);
        checkOutput({tag, "_busy_b"}, 32'(busy_b), 32'd1);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        cyc        = 0;
        m_busy     = 1'b1;
        m_cnt      = 0;
        rst        = 1'b1;
        we         = 1'b0;
        write_addr = 4'd0;
        data       = 16'h0000;
        be         = 2'b00;
        re         = 1'b0;
        read_addr  = 4'd0;
        clear_req  = 1'b0;
        for (int i = 0; i < 16; i++) m_mem[i] = 16'hxxxx;

        @(posedge clk);
        cyc++;
        #1;
        checkResetState("reset");
        rst = 1'b0;

        $display("[TB] power-on clear then read all addresses");
        for (int i = 0; i < 16; i++) idleCycle();
        for (int a = 0; a < 16; a++) readAddr(4'(a));
        idleCycle();
        idleCycle();

        $display("[TB] byte-enable writes");
        writeAddr(4'd3, 16'h1234, 2'b11);
        writeAddr(4'd3, 16'hFF77, 2'b10);
        readAddr(4'd3);
        idleCycle();
        idleCycle();

        $display("[TB] read/write collision");
        writeAddr(4'd5, 16'h0001, 2'b11);
        applyStimulus(1'b1, 4'd5, 16'hBEEF, 2'b11, 1'b1, 4'd5, 1'b0);
        readAddr(4'd5);
        idleCycle();
        idleCycle();

        $display("[TB] clear request with reads in flight");
        writeAddr(4'd1, 16'h1111, 2'b11);
        writeAddr(4'd2, 16'h2222, 2'b11);
        readAddr(4'd1);
        readAddr(4'd2);
        applyStimulus(1'b1, 4'd0, 16'hDEAD, 2'b11, 1'b1, 4'd0, 1'b1);
        for (int i = 0; i < 16; i++) idleCycle();
        readAddr(4'd0);
        readAddr(4'd1);
        idleCycle();
        idleCycle();

        $display("[TB] reset in the middle of a clear");
        writeAddr(4'd9, 16'h9999, 2'b11);
        readAddr(4'd9);
        idleCycle();
        idleCycle();
        applyStimulus(1'b0, 4'd0, 16'h0000, 2'b00, 1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 9; i++) idleCycle();
        rst = 1'b1;
        #1;
        checkResetState("midrst");
        qa.delete();
        qb.delete();
        m_busy = 1'b1;
        m_cnt  = 0;
        @(posedge clk);
        cyc++;
        #1;
        rst = 1'b0;

        $display("[TB] user traffic while busy");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 4'($urandom_range(0, 15)), 16'($urandom), 2'b11,
                          1'b1, 4'($urandom_range(0, 15)), 1'b0);
        end
        for (int a = 0; a < 16; a++) readAddr(4'(a));
        idleCycle();
        idleCycle();

        checkOutput("drain_a", 32'(qa.size()), 32'd0);
        checkOutput("drain_b", 32'(qb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
